// File: rtl/keypad_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl_if
// Purpose  : Row/column strobes and accepted-key outputs of the keypad scanner.
// Revision : 1.0
// ============================================================================
interface keypad_scan_ctrl_if;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_held;

    modport master (
        output row_out,
        output onehot,
        output key_valid,
        output key_held,
        input  col_in
    );

    modport slave (
        input  row_out,
        input  onehot,
        input  key_valid,
        input  key_held,
        output col_in
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 keypad row scanner with frame-based press/release debounce.
// Revision : 1.0
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    keypad_scan_ctrl_if.master  kp
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] C_DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  C_DEB      = 8'(DEBOUNCE_FRAMES);

    logic [15:0] r_div;
    logic [1:0]  r_row;
    logic [15:0] r_frame;
    state_t      r_state;
    logic [7:0]  r_count;
    logic [15:0] r_cand;
    logic [15:0] r_onehot;
    logic        r_valid;
    logic        r_held;

    logic        w_sample;
    logic        w_frame_done;
    logic [15:0] w_frame_full;
    logic        w_empty;
    logic        w_single;
    logic [7:0]  w_count_inc;

    state_t      w_state_nx;
    logic [7:0]  w_count_nx;
    logic [15:0] w_cand_nx;
    logic [15:0] w_onehot_nx;
    logic        w_valid_nx;
    logic        w_held_nx;

    assign w_sample     = (r_div == C_DIV_LAST);
    assign w_frame_done = w_sample && (r_row == 2'd3);

    // The row-3 hits are merged combinationally so the frame can be judged in its sampling cycle.
    always_comb begin
        w_frame_full = r_frame;
        if (w_sample) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.col_in[c]) begin
                    w_frame_full[{r_row, c[1:0]}] = 1'b1;
                end
            end
        end
    end

    assign w_empty     = (w_frame_full == 16'h0000);
    assign w_single    = !w_empty && ((w_frame_full & (w_frame_full - 16'd1)) == 16'h0000);
    assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_cand_nx   = r_cand;
        w_onehot_nx = r_onehot;
        w_valid_nx  = 1'b0;
        w_held_nx   = r_held;
        if (w_frame_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nx  = w_frame_full;
                        w_count_nx = 8'd1;
                        if (C_DEB <= 8'd1) begin
                            w_state_nx  = S_HELD;
                            w_onehot_nx = w_frame_full;
                            w_valid_nx  = 1'b1;
                            w_held_nx   = 1'b1;
                        end else begin
                            w_state_nx = S_PRESS;
                        end
                    end
                end
                S_PRESS: begin
                    if (!w_single) begin
                        w_state_nx = S_IDLE;
                    end else if (w_frame_full == r_cand) begin
                        w_count_nx = w_count_inc;
                        if (w_count_inc >= C_DEB) begin
                            w_state_nx  = S_HELD;
                            w_onehot_nx = r_cand;
                            w_valid_nx  = 1'b1;
                            w_held_nx   = 1'b1;
                        end
                    end else begin
                        w_cand_nx  = w_frame_full;
                        w_count_nx = 8'd1;
                    end
                end
                S_HELD: begin
                    if (w_empty) begin
                        w_count_nx = 8'd1;
                        if (C_DEB <= 8'd1) begin
                            w_state_nx = S_IDLE;
                            w_held_nx  = 1'b0;
                        end else begin
                            w_state_nx = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (w_empty) begin
                        w_count_nx = w_count_inc;
                        if (w_count_inc >= C_DEB) begin
                            w_state_nx = S_IDLE;
                            w_held_nx  = 1'b0;
                        end
                    end else begin
                        w_state_nx = S_HELD;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= 16'd0;
            r_row    <= 2'd0;
            r_frame  <= 16'h0000;
            r_state  <= S_IDLE;
            r_count  <= 8'd0;
            r_cand   <= 16'h0000;
            r_onehot <= 16'h0000;
            r_valid  <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            if (w_sample) begin
                r_div <= 16'd0;
                r_row <= r_row + 2'd1;
            end else begin
                r_div <= r_div + 16'd1;
            end
            r_frame  <= w_frame_done ? 16'h0000 : w_frame_full;
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_cand   <= w_cand_nx;
            r_onehot <= w_onehot_nx;
            r_valid  <= w_valid_nx;
            r_held   <= w_held_nx;
        end
    end

    assign kp.row_out   = ~(4'b0001 << r_row);
    assign kp.onehot    = r_onehot;
    assign kp.key_valid = r_valid;
    assign kp.key_held  = r_held;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Directed frame-level vectors for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_FRAMES=2).
// Revision : 1.0
// ============================================================================
module tb_keypad_scan_ctrl;
    localparam int C_FRAME = 16;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_valids;
        logic        exp_held;
        logic [15:0] exp_onehot;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] r_keys;
    logic [3:0]  w_col;
    int          n_vec;
    int          n_err;

    keypad_scan_ctrl_if u_if ();

    keypad_scan_ctrl #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .kp  (u_if)
    );

    // Keypad model: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        w_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!u_if.row_out[r] && r_keys[r*4 + c]) begin
                    w_col[c] = 1'b0;
                end
            end
        end
    end
    assign u_if.col_in = w_col;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frames(input int n, output int nvalid, output int lastpos, output int consec);
        logic prev;
        nvalid  = 0;
        lastpos = -1;
        consec  = 0;
        prev    = 1'b0;
        for (int f = 0; f < n; f++) begin
            for (int k = 1; k <= C_FRAME; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (u_if.key_valid) begin
                    nvalid++;
                    lastpos = k;
                    if (prev) consec++;
                end
                prev = u_if.key_valid;
            end
        end
    endtask

    vec_t vecs[16];

    initial begin
        int nv, pos, cons;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{16'h0080, 1, 0, 1'b0, 16'h0000};
        vecs[1]  = '{16'h0000, 1, 0, 1'b0, 16'h0000};
        vecs[2]  = '{16'h0048, 4, 0, 1'b0, 16'h0000};
        vecs[3]  = '{16'h0080, 2, 1, 1'b1, 16'h0080};
        vecs[4]  = '{16'h0080, 1, 0, 1'b1, 16'h0080};
        vecs[5]  = '{16'h0000, 1, 0, 1'b1, 16'h0080};
        vecs[6]  = '{16'h0080, 1, 0, 1'b1, 16'h0080};
        vecs[7]  = '{16'h0200, 1, 0, 1'b1, 16'h0080};
        vecs[8]  = '{16'h0048, 1, 0, 1'b1, 16'h0080};
        vecs[9]  = '{16'h0000, 2, 0, 1'b0, 16'h0080};
        vecs[10] = '{16'h0200, 2, 1, 1'b1, 16'h0200};
        vecs[11] = '{16'h0000, 2, 0, 1'b0, 16'h0200};
        vecs[12] = '{16'h0080, 1, 0, 1'b0, 16'h0200};
        vecs[13] = '{16'h0001, 1, 0, 1'b0, 16'h0200};
        vecs[14] = '{16'h0001, 1, 1, 1'b1, 16'h0001};
        vecs[15] = '{16'h0000, 2, 0, 1'b0, 16'h0001};

        rst    = 1'b1;
        r_keys = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset row_out", 32'(u_if.row_out), 32'h0000_000E);
        chk("reset onehot", 32'(u_if.onehot), 32'h0);
        chk("reset key_valid", 32'(u_if.key_valid), 32'h0);
        chk("reset key_held", 32'(u_if.key_held), 32'h0);
        rst = 1'b0;

        // One empty frame with the row strobe checked every cycle.
        for (int k = 1; k <= C_FRAME; k++) begin
            logic [3:0] exp_row;
            @(posedge clk);
            @(negedge clk);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("row_out cycle %0d", k), 32'(u_if.row_out), 32'(exp_row));
        end

        for (int i = 0; i < 16; i++) begin
            r_keys = vecs[i].keys;
            run_frames(vecs[i].frames, nv, pos, cons);
            chk($sformatf("vec%0d valid pulses", i), 32'(nv), 32'(vecs[i].exp_valids));
            if (vecs[i].exp_valids == 1) begin
                chk($sformatf("vec%0d valid position", i), 32'(pos), 32'(C_FRAME));
            end
            chk($sformatf("vec%0d valid back-to-back", i), 32'(cons), 32'h0);
            chk($sformatf("vec%0d key_held", i), 32'(u_if.key_held), 32'(vecs[i].exp_held));
            chk($sformatf("vec%0d onehot", i), 32'(u_if.onehot), 32'(vecs[i].exp_onehot));
        end

        // Reset in the middle of a held key, then re-acceptance from scratch.
        r_keys = 16'h0080;
        run_frames(2, nv, pos, cons);
        chk("pre-reset valid pulses", 32'(nv), 32'd1);
        chk("pre-reset key_held", 32'(u_if.key_held), 32'h1);
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid reset row_out", 32'(u_if.row_out), 32'h0000_000E);
        chk("mid reset onehot", 32'(u_if.onehot), 32'h0);
        chk("mid reset key_valid", 32'(u_if.key_valid), 32'h0);
        chk("mid reset key_held", 32'(u_if.key_held), 32'h0);
        rst = 1'b0;
        run_frames(1, nv, pos, cons);
        chk("post-reset frame1 valid", 32'(nv), 32'd0);
        chk("post-reset frame1 held", 32'(u_if.key_held), 32'h0);
        run_frames(1, nv, pos, cons);
        chk("post-reset frame2 valid", 32'(nv), 32'd1);
        chk("post-reset frame2 position", 32'(pos), 32'(C_FRAME));
        chk("post-reset held", 32'(u_if.key_held), 32'h1);
        chk("post-reset onehot", 32'(u_if.onehot), 32'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
